// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared constants for the mesh NoC router:
//   - flit type codes carried in the two MSBs of every flit
//   - router port indices (north, east, south, west, local)
//   - flit_type_f(): extracts the flit type from a flit of any width <= 64
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam logic [1:0] FLIT_BODY      = 2'b00;
    localparam logic [1:0] FLIT_HEAD      = 2'b01;
    localparam logic [1:0] FLIT_TAIL      = 2'b10;
    localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

    localparam int PORT_NORTH = 0;
    localparam int PORT_EAST  = 1;
    localparam int PORT_SOUTH = 2;
    localparam int PORT_WEST  = 3;
    localparam int PORT_LOCAL = 4;

    // Caller zero-extends the flit to 64 bits and passes its real width so
    // one helper serves every FLIT_SIZE.
    function automatic logic [1:0] flit_type_f(input logic [63:0] flit,
                                               input int          flit_size);
        return flit[flit_size-2 +: 2];
    endfunction

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The requester whose index is the
// smallest distance at or above i_ptr (wrapping modulo N) wins.
// Ports:
//   i_req   [N-1:0]  request vector
//   i_ptr   [PW-1:0] highest-priority index (must be < N)
//   o_gnt   [N-1:0]  one-hot grant (all zero when no request)
//   o_idx   [PW-1:0] encoded index of the granted requester
//   o_valid          a grant was issued
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 5,
    parameter int PW = 3
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_valid
);

    // Pick the requester with the smallest wrapped distance from the pointer
    always_comb begin
        int  v_best;
        int  v_idx;
        int  v_d;
        logic v_take;
        v_best = N;
        v_idx  = 0;
        v_d    = 0;
        v_take = 1'b0;
        for (int i = 0; i < N; i++) begin
            v_d    = (i + N - int'(i_ptr)) % N;
            v_take = i_req[i] && (v_d < v_best);
            v_best = v_take ? v_d : v_best;
            v_idx  = v_take ? i : v_idx;
        end
        o_valid = (v_best < N);
        o_idx   = PW'(v_idx);
        o_gnt   = '0;
        for (int i = 0; i < N; i++) begin
            o_gnt[i] = o_valid && (v_idx == i);
        end
    end

endmodule

// File: rtl/switch_allocator_rr.sv
// -----------------------------------------------------------------------------
// switch_allocator_rr
// Wormhole switch allocator: one round-robin arbiter and one IDLE/LOCKED FSM per
// output port. A HEAD flit locks the output to its input until the TAIL passes;
// HEAD_TAIL flits are forwarded without locking. ON_OFF back-pressure freezes
// an output for the cycle without disturbing its lock or pointer.
// Ports:
//   clk, rst_n       clock / asynchronous active-low reset
//   op_port          requested output code per input (OP_SIZE bits each)
//   in_valid         input buffer i holds a head flit
//   in_buf           head flit of each input buffer
//   ON_OFF_signal    downstream of output o can accept a flit
//   rd_en            combinational pop strobe per input (0 during reset)
//   wr_en            registered write strobe per output
//   op_flit          registered flit per output (holds when idle)
//   out_locked       output o is LOCKED to an owner input
// -----------------------------------------------------------------------------
module switch_allocator_rr
    import noc_pkg::*;
#(
    parameter int NUM_PORTS = 5,
    parameter int FLIT_SIZE = 8,
    parameter int OP_SIZE   = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS*OP_SIZE-1:0]   op_port,
    input  logic [NUM_PORTS-1:0]           in_valid,
    input  logic [NUM_PORTS*FLIT_SIZE-1:0] in_buf,
    input  logic [NUM_PORTS-1:0]           ON_OFF_signal,
    output logic [NUM_PORTS-1:0]           rd_en,
    output logic [NUM_PORTS-1:0]           wr_en,
    output logic [NUM_PORTS*FLIT_SIZE-1:0] op_flit,
    output logic [NUM_PORTS-1:0]           out_locked
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Row o holds the one-hot grant vector of output o
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_gnt_all;

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        logic [0:0]           r_state;
        logic [OP_SIZE-1:0]   r_owner;
        logic [OP_SIZE-1:0]   r_rr_ptr;
        logic                 r_wr_en;
        logic [FLIT_SIZE-1:0] r_op_flit;

        logic [NUM_PORTS-1:0] w_req;
        logic [NUM_PORTS-1:0] w_gnt;
        logic [OP_SIZE-1:0]   w_gidx;
        logic                 w_gvalid;
        logic [FLIT_SIZE-1:0] w_gflit;
        logic [1:0]           w_gtype;
        logic [0:0]           w_nstate;
        logic [OP_SIZE-1:0]   w_nowner;
        logic [OP_SIZE-1:0]   w_nptr;

        // Eligible requests: only heads while IDLE, only the owner while LOCKED
        always_comb begin
            logic [1:0] v_type;
            w_req  = '0;
            v_type = FLIT_BODY;
            for (int i = 0; i < NUM_PORTS; i++) begin
                v_type = flit_type_f(64'(in_buf[i*FLIT_SIZE +: FLIT_SIZE]), FLIT_SIZE);
                if (in_valid[i] && ON_OFF_signal[o] &&
                    (op_port[i*OP_SIZE +: OP_SIZE] == OP_SIZE'(o))) begin
                    if (r_state == ST_LOCKED) begin
                        w_req[i] = (r_owner == OP_SIZE'(i));
                    end else begin
                        w_req[i] = (v_type == FLIT_HEAD) || (v_type == FLIT_HEAD_TAIL);
                    end
                end else begin
                    w_req[i] = 1'b0;
                end
            end
        end

        // While LOCKED only the owner requests, so the arbiter returns it
        rr_arbiter #(
            .N  (NUM_PORTS),
            .PW (OP_SIZE)
        ) u_arb (
            .i_req   (w_req),
            .i_ptr   (r_rr_ptr),
            .o_gnt   (w_gnt),
            .o_idx   (w_gidx),
            .o_valid (w_gvalid)
        );

        // AND-OR mux of the granted input's flit (grant is one-hot)
        always_comb begin
            w_gflit = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_gflit = w_gflit | ({FLIT_SIZE{w_gnt[i]}} & in_buf[i*FLIT_SIZE +: FLIT_SIZE]);
            end
        end

        assign w_gtype = flit_type_f(64'(w_gflit), FLIT_SIZE);

        // FSM next state, owner and round-robin pointer
        always_comb begin
            w_nstate = r_state;
            w_nowner = r_owner;
            w_nptr   = r_rr_ptr;
            if (w_gvalid) begin
                case (r_state)
                    ST_IDLE: begin
                        // Pointer only moves on a new packet, never on body/tail
                        w_nptr = (w_gidx == OP_SIZE'(NUM_PORTS-1)) ? '0 : (w_gidx + OP_SIZE'(1));
                        case (w_gtype)
                            FLIT_HEAD: begin
                                w_nstate = ST_LOCKED;
                                w_nowner = w_gidx;
                            end
                            FLIT_HEAD_TAIL: w_nstate = ST_IDLE;
                            default:        w_nstate = ST_IDLE;
                        endcase
                    end
                    ST_LOCKED: begin
                        case (w_gtype)
                            FLIT_TAIL: w_nstate = ST_IDLE;
                            default:   w_nstate = ST_LOCKED;
                        endcase
                    end
                    default: w_nstate = ST_IDLE;
                endcase
            end else begin
                w_nstate = r_state;
                w_nowner = r_owner;
                w_nptr   = r_rr_ptr;
            end
        end

        // State and output registers; op_flit holds when nothing is granted
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state   <= ST_IDLE;
                r_owner   <= '0;
                r_rr_ptr  <= '0;
                r_wr_en   <= 1'b0;
                r_op_flit <= '0;
            end else begin
                r_state   <= w_nstate;
                r_owner   <= w_nowner;
                r_rr_ptr  <= w_nptr;
                r_wr_en   <= w_gvalid;
                r_op_flit <= w_gvalid ? w_gflit : r_op_flit;
            end
        end

        assign w_gnt_all[o]                          = w_gnt;
        assign wr_en[o]                              = r_wr_en;
        assign op_flit[o*FLIT_SIZE +: FLIT_SIZE]     = r_op_flit;
        assign out_locked[o]                         = (r_state == ST_LOCKED);
    end

    // Each input targets one output, so OR-ing the grant rows gives its pop strobe
    always_comb begin
        logic [NUM_PORTS-1:0] v_acc;
        v_acc = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            v_acc = v_acc | w_gnt_all[o];
        end
        if (rst_n) begin
            rd_en = v_acc;
        end else begin
            rd_en = '0;
        end
    end

endmodule
